fifo_status: RTL and testbench

Parametrised synchronous FIFO that succeeds the team's basic FIFO. It adds programmable almost-full/almost-empty thresholds, a fill-level count, and sticky overflow/underflow error flags with a clear input. A parameter selects either registered-read mode or first-word-fall-through (FWFT) mode. It sits between a producer and consumer in the same clock domain and buffers bursts while reporting its fill level to flow control logic.

---
 rtl/fifo_status.sv | 128 ++++++++++++
 tb/tb_fifo_status.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status.sv
// Synchronous FIFO with fill-level count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, and registered-read or FWFT output.
module fifo_status #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          clr_err,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic                  underflow_reg;
  logic                  underflow_next;
  logic                  rd_accept;
  logic                  wr_accept;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_CNT);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_accept = cs & rd_en & ~empty;
  assign wr_accept = cs & wr_en & (~full | rd_accept);

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      count_next = count_reg - 1'b1;
    end
  end

  // A new error in the clearing cycle takes priority over clr_err.
  always_comb begin
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (cs && clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (cs && wr_en && !wr_accept) begin
      overflow_next = 1'b1;
    end
    if (cs && rd_en && !rd_accept) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is not cleared by reset, but a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_WIDTH-1:0] data_out_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          data_out_reg <= '0;
        end else if (rd_accept) begin
          data_out_reg <= mem[rd_ptr_reg];
        end
      end

      assign data_out = data_out_reg;
    end else begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads 0.
      assign data_out = empty ? '0 : mem[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: one stimulus drives a registered-read and an FWFT
// instance side by side, checked each cycle against a queue model.
module tb_fifo_status;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        wr_en;
  logic        rd_en;
  logic        clr_err;
  logic [31:0] data_in;

  logic [31:0] data_out0, data_out1;
  logic        full0, full1, empty0, empty1;
  logic        af0, af1, ae0, ae1;
  logic [3:0]  count0, count1;
  logic        ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  logic [31:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [31:0] m_dout0 = 32'd0;

  fifo_status #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u0 (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_status #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u1 (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words; a read pops the head, a write pushes the tail.
  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (!reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_dout0 = 32'd0;
    end else begin
      rd_ok = cs && rd_en && (q.size() > 0);
      wr_ok = cs && wr_en && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout0 = q.pop_front();
      if (wr_ok) q.push_back(data_in);
      if (cs && clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (cs && wr_en && !wr_ok) m_ovf = 1'b1;
      if (cs && rd_en && !rd_ok) m_unf = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int n;
      n = q.size();
      chk("count0", 32'(count0), 32'(n));
      chk("count1", 32'(count1), 32'(n));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("empty1", 32'(empty1), 32'(n == 0));
      chk("full0",  32'(full0),  32'(n == DEPTH));
      chk("full1",  32'(full1),  32'(n == DEPTH));
      chk("af0",    32'(af0),    32'(n >= AF));
      chk("af1",    32'(af1),    32'(n >= AF));
      chk("ae0",    32'(ae0),    32'(n <= AE));
      chk("ae1",    32'(ae1),    32'(n <= AE));
      chk("ovf0",   32'(ovf0),   32'(m_ovf));
      chk("ovf1",   32'(ovf1),   32'(m_ovf));
      chk("unf0",   32'(unf0),   32'(m_unf));
      chk("unf1",   32'(unf1),   32'(m_unf));
      chk("dout0",  data_out0,   m_dout0);
      if (n > 0) chk("dout1", data_out1, q[0]);
    end
  end

  task automatic step(input logic c, input logic w, input logic r, input logic cl,
                      input logic [31:0] d);
    cs = c; wr_en = w; rd_en = r; clr_err = cl; data_in = d;
    @(posedge clk);
    #1;
    $display("txn cs=%0b wr=%0b rd=%0b clr=%0b din=0x%08h -> cnt=%0d dout0=0x%08h dout1=0x%08h ovf=%0b unf=%0b",
             c, w, r, cl, d, count0, data_out0, data_out1, ovf0, unf0);
  endtask

  initial begin
    reset = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0; data_in = 32'hDEAD_BEEF;

    // Reset held with a write pending: nothing may be stored
    step(1, 1, 0, 0, 32'hDEAD_BEEF);
    step(1, 1, 0, 0, 32'hDEAD_BEEF);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_ae",    32'(ae0),    32'd1);
    chk("rst_dout",  data_out0,   32'd0);
    reset = 1'b1;
    check_en = 1'b1;
    step(1, 0, 0, 0, 32'd0);
    chk("rst_nowrite", 32'(empty0), 32'd1);

    // Basic ordering, registered read
    step(1, 1, 0, 0, 32'd1);
    step(1, 1, 0, 0, 32'd10);
    step(1, 1, 0, 0, 32'd100);
    step(1, 0, 1, 0, 32'd0); chk("ord_rd1", data_out0, 32'd1);
    step(1, 0, 1, 0, 32'd0); chk("ord_rd2", data_out0, 32'd10);
    step(1, 0, 1, 0, 32'd0); chk("ord_rd3", data_out0, 32'd100);
    step(1, 0, 1, 0, 32'd0);
    chk("ord_hold",  data_out0,   32'd100);
    chk("ord_unf",   32'(unf0),   32'd1);
    chk("ord_empty", 32'(empty0), 32'd1);
    // clr_err colliding with a fresh underflow keeps the flag
    step(1, 0, 1, 1, 32'd0); chk("clr_vs_err", 32'(unf0), 32'd1);
    step(1, 0, 0, 1, 32'd0); chk("clr_unf",    32'(unf0), 32'd0);

    // Fill, thresholds and overflow
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0, 32'd1 << i);
      if (i == 1) chk("ae_at2", 32'(ae0), 32'd1);
      if (i == 2) chk("ae_at3", 32'(ae0), 32'd0);
      if (i == 4) chk("af_at5", 32'(af0), 32'd0);
      if (i == 5) chk("af_at6", 32'(af0), 32'd1);
      if (i == 7) chk("full_at8", 32'(full0), 32'd1);
    end
    chk("ovf_set",   32'(ovf0),   32'd1);
    chk("ovf_count", 32'(count0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 0, 32'd0);
      chk("fill_rd", data_out0, 32'd1 << i);
    end
    step(1, 0, 0, 1, 32'd0); chk("clr_ovf", 32'(ovf0), 32'd0);

    // Simultaneous read+write on full, then on empty
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 32'h10 + 32'(i));
    step(1, 1, 1, 0, 32'hAA);
    chk("sim_full_ovf", 32'(ovf0),   32'd0);
    chk("sim_full_cnt", 32'(count0), 32'd8);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 32'd0);
    chk("sim_full_last", data_out0, 32'hAA);
    step(1, 1, 1, 0, 32'h55);
    chk("sim_empty_unf", 32'(unf0),   32'd1);
    chk("sim_empty_cnt", 32'(count0), 32'd1);
    step(1, 0, 1, 1, 32'd0); chk("sim_empty_rd", data_out0, 32'h55);

    // FWFT behaviour and mid-burst reset
    step(1, 1, 0, 0, 32'd5);
    chk("fwft_first", data_out1,         32'd5);
    chk("fwft_nempty", 32'(empty1),      32'd0);
    step(1, 0, 1, 0, 32'd0); chk("fwft_empty", 32'(empty1), 32'd1);
    step(1, 1, 0, 0, 32'd7);
    step(1, 1, 0, 0, 32'd8);
    step(1, 1, 0, 0, 32'd9);
    chk("fwft_cnt3", 32'(count1), 32'd3);
    reset = 1'b0;
    step(1, 1, 0, 0, 32'd11);
    reset = 1'b1;
    chk("midrst_cnt",   32'(count1), 32'd0);
    chk("midrst_empty", 32'(empty1), 32'd1);

    // Chip select low masks every request
    step(0, 1, 0, 0, 32'd3);
    step(0, 0, 1, 0, 32'd0);
    chk("cs_nowrite", 32'(count0), 32'd0);
    chk("cs_nounf",   32'(unf0),   32'd0);

    // Mixed traffic against the model
    for (int i = 0; i < 120; i++) begin
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 15) == 0), $urandom);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
